// File: rtl/pipeline_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encoding, the canonical NOP
// instruction and the register-address width.
package pipeline_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the operands
// read by the instruction in ID.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  uses_rs1_i,
    input  logic                  uses_rs2_i,
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  lu_o
);

    // x0 is hard-wired to zero, so a load targeting it can never create a hazard.
    always_comb begin
        lu_o = mem_read_i && (rd_i != '0) &&
               ((uses_rs1_i && (rd_i == rs1_i)) || (uses_rs2_i && (rd_i == rs2_i)));
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// IF/ID and PC sequencing for the 5-stage core: load-use stalls, imem waits and
// branch flushes. Define HAZARD_PERF_CNT_EN to add stall/flush performance counters.
module hazard_ctrl_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  imem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_cycles
`endif
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_CNT  = 8'(MEM_TIMEOUT);

    hazard_state_e state_q, state_d;
    logic [2:0]    flush_cnt_q, flush_cnt_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          pending_flush_q, pending_flush_d;
    logic          err_q, err_d;
    logic          lu;
    logic          enter_flush;

    load_use_detect u_lu (
        .rs1_i      (id_rs1),
        .rs2_i      (id_rs2),
        .uses_rs1_i (id_uses_rs1),
        .uses_rs2_i (id_uses_rs2),
        .mem_read_i (ex_mem_read),
        .rd_i       (ex_rd),
        .lu_o       (lu)
    );

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        pending_flush_d = pending_flush_q;
        enter_flush     = 1'b0;
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    enter_flush = 1'b1;
                end else if (!imem_ready) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = 8'd1;
                end else if (lu) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                pc_write     = imem_ready;
                if (ex_branch_taken) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (imem_ready) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                pc_write     = ex_branch_taken;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (imem_ready) begin
                    wait_cnt_d      = 8'd0;
                    pending_flush_d = 1'b0;
                    state_d         = RUN;
                    if (pending_flush_q || ex_branch_taken) enter_flush = 1'b1;
                end else begin
                    if (ex_branch_taken) pending_flush_d = 1'b1;
                    if (wait_cnt_q != TIMEOUT_CNT) wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase

        // A deferred branch from MEM_WAIT replays exactly the RUN-state branch entry.
        if (enter_flush) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_cnt_d  = FLUSH_RELOAD;
            state_d      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end

        err_d = err_q || (wait_cnt_d == TIMEOUT_CNT);

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= RUN;
            flush_cnt_q     <= 3'd0;
            wait_cnt_q      <= 8'd0;
            pending_flush_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            pending_flush_q <= pending_flush_d;
            err_q           <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cycles_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q    <= 32'd0;
            flush_cycles_q <= 32'd0;
        end else begin
            if (!pc_write && !if_id_flush) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_id_flush) flush_cycles_q <= flush_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule
